// File: rtl/riscv_pkg.sv
// Shared types for the RV32I memory-port arbiter: FSM state encoding and byte-enable width.
package riscv_pkg;

  localparam int unsigned BE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE
  } arb_state_t;

endpackage

// File: rtl/arb_run_counter.sv
// Saturating count of consecutive data grants made while a fetch was waiting.
module arb_run_counter #(
  parameter int unsigned MAX_RUN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int unsigned CW = $clog2(MAX_RUN + 1);

  logic [CW-1:0] r_cnt;

  // Clear wins over increment: a data grant with no fetch waiting starts no run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CW'(MAX_RUN))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == CW'(MAX_RUN));

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter for the single-port unified memory, one transaction in flight.
// Optional busy watchdog with sticky err: define MEM_PORT_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_D_RUN   = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m,
  output logic              err
);

  if (MAX_D_RUN == 0 || TIMEOUT_CYC == 0) begin : g_param_chk
    $error("mem_port_arbiter: MAX_D_RUN and TIMEOUT_CYC must be nonzero");
  end

  arb_state_t        r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [BE_W-1:0]   r_mem_be;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_valid;
  logic              r_d_valid;

  logic w_idle;
  logic w_busy;
  logic w_at_limit;
  logic w_grant_d;
  logic w_grant_i;
  logic w_run_clr;
  logic w_timeout;
  logic w_done;

  assign w_idle    = (r_state == IDLE);
  assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign w_grant_d = w_idle && d_req && (!if_req || !w_at_limit);
  assign w_grant_i = w_idle && if_req && !w_grant_d;
  assign w_run_clr = w_idle && (!if_req || w_grant_i);
  assign w_done    = w_busy && (mem_ready || w_timeout);

  arb_run_counter #(
    .MAX_RUN (MAX_D_RUN)
  ) u_run (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (w_grant_d),
    .i_clr      (w_run_clr),
    .o_at_limit (w_at_limit)
  );

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_err;

  assign w_timeout = w_busy && !mem_ready && (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_busy && !mem_ready && !w_timeout) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state     <= BUSY_D;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_mem_be    <= d_be;
          end else if (w_grant_i) begin
            r_state     <= BUSY_I;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_be    <= '1;
          end
        end
        BUSY_I: begin
          if (w_done) begin
            r_state    <= DONE;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_if_valid <= 1'b1;
            r_if_rdata <= mem_ready ? mem_rdata : '0;
          end
        end
        BUSY_D: begin
          if (w_done) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_d_valid <= 1'b1;
            // Stores keep the previous load data; a timed-out access returns zero.
            if (!r_mem_we || !mem_ready) begin
              r_d_rdata <= mem_ready ? mem_rdata : '0;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_valid  = r_if_valid;
  assign d_valid   = r_d_valid;
  assign stall_f   = if_req && !r_if_valid;
  assign stall_m   = d_req && !r_d_valid;

endmodule
